// File: rtl/game_board_cursor_draw.sv
// Cursor overlay stage for the VGA pipeline.
// Draws a blinking one-pixel frame around the selected cell of the N x N grid
// (N = board_size^2). It owns the cursor position, which moves by one cell per
// direction pulse and wraps at the grid edges. All bus timing signals are
// delayed by exactly one clock. blink_on and frame_cnt are exported so the
// blink state can be observed directly.
module game_board_cursor_draw #(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] CURSOR_COLOR = 12'hf_0_0,
  parameter int          CHAR_WIDTH   = 8,
  parameter int          CHAR_HEIGHT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_game_on,
  input  logic [2:0]  board_size,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic [10:0] bus_in_hcount,
  input  logic        bus_in_hsync,
  input  logic        bus_in_hblnk,
  input  logic [10:0] bus_in_vcount,
  input  logic        bus_in_vsync,
  input  logic        bus_in_vblnk,
  input  logic [11:0] bus_in_rgb,
  output logic [10:0] bus_out_hcount,
  output logic        bus_out_hsync,
  output logic        bus_out_hblnk,
  output logic [10:0] bus_out_vcount,
  output logic        bus_out_vsync,
  output logic        bus_out_vblnk,
  output logic [11:0] bus_out_rgb,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        blink_on,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] LAST_FRAME = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0] CW         = 16'(CHAR_WIDTH);
  localparam logic [15:0] CH         = 16'(CHAR_HEIGHT);

  // Cursor and blink state
  logic [3:0]  r_cx, r_cy;
  logic [15:0] r_cnt;
  logic        r_blink;
  logic        r_vsync_prev;

  // Next-state values
  logic [3:0]  w_cx_nxt, w_cy_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_blink_nxt;

  // Grid order and move decode
  logic [15:0] w_n, w_nm1;
  logic [3:0]  w_max;
  logic        w_size_ok, w_x_oob, w_y_oob;
  logic        w_up, w_down, w_left, w_right;
  logic        w_move, w_tick;

  // Geometry and overlay
  logic [15:0] w_gx, w_gy, w_x0, w_x1, w_y0, w_y1, w_h, w_v;
  logic        w_in_cell, w_edge, w_draw;

  assign w_n       = {13'd0, board_size} * {13'd0, board_size};
  assign w_nm1     = w_n - 16'd1;
  assign w_max     = w_nm1[3:0];
  assign w_size_ok = (board_size >= 3'd2) && (board_size <= 3'd4);
  assign w_x_oob   = ({12'd0, r_cx} >= w_n);
  assign w_y_oob   = ({12'd0, r_cy} >= w_n);

  // Opposite pulses in the same cycle cancel each other out.
  assign w_up    = move_up & ~move_down;
  assign w_down  = move_down & ~move_up;
  assign w_left  = move_left & ~move_right;
  assign w_right = move_right & ~move_left;
  assign w_move  = is_game_on & w_size_ok & (w_up | w_down | w_left | w_right);
  assign w_tick  = bus_in_vsync & ~r_vsync_prev;

  // Next cursor position: game-off reset, hold on bad size, clamp after shrink, wrap moves
  always_comb begin
    w_cx_nxt = r_cx;
    w_cy_nxt = r_cy;
    if (!is_game_on) begin
      w_cx_nxt = 4'd0;
      w_cy_nxt = 4'd0;
    end else if (w_size_ok) begin
      if (w_x_oob)       w_cx_nxt = 4'd0;
      else if (w_left)   w_cx_nxt = (r_cx == 4'd0)  ? w_max : r_cx - 4'd1;
      else if (w_right)  w_cx_nxt = (r_cx == w_max) ? 4'd0  : r_cx + 4'd1;
      if (w_y_oob)       w_cy_nxt = 4'd0;
      else if (w_up)     w_cy_nxt = (r_cy == 4'd0)  ? w_max : r_cy - 4'd1;
      else if (w_down)   w_cy_nxt = (r_cy == w_max) ? 4'd0  : r_cy + 4'd1;
    end
  end

  // Next blink state: moves restart the visible phase and win over a frame tick
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_blink_nxt = r_blink;
    if (!is_game_on || w_move) begin
      w_cnt_nxt   = 16'd0;
      w_blink_nxt = 1'b1;
    end else if (w_tick) begin
      if (r_cnt == LAST_FRAME) begin
        w_cnt_nxt   = 16'd0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end
  end

  // Frame-pixel test for the selected cell using the current cursor
  always_comb begin
    w_gx = (16'd1024 - CW * w_n) >> 1;
    w_gy = (16'd768 - CH * w_n) >> 1;
    w_x0 = w_gx + CW * {12'd0, r_cx};
    w_x1 = w_x0 + CW - 16'd1;
    w_y0 = w_gy + CH * {12'd0, r_cy};
    w_y1 = w_y0 + CH - 16'd1;
    w_h  = {5'd0, bus_in_hcount};
    w_v  = {5'd0, bus_in_vcount};
    w_in_cell = (w_h >= w_x0) && (w_h <= w_x1) && (w_v >= w_y0) && (w_v <= w_y1);
    w_edge    = (w_h == w_x0) || (w_h == w_x1) || (w_v == w_y0) || (w_v == w_y1);
    w_draw    = is_game_on & w_size_ok & r_blink & w_in_cell & w_edge;
  end

  // Cursor, blink and vsync-edge registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx         <= 4'd0;
      r_cy         <= 4'd0;
      r_cnt        <= 16'd0;
      r_blink      <= 1'b1;
      r_vsync_prev <= 1'b0;
    end else begin
      r_cx         <= w_cx_nxt;
      r_cy         <= w_cy_nxt;
      r_cnt        <= w_cnt_nxt;
      r_blink      <= w_blink_nxt;
      r_vsync_prev <= bus_in_vsync;
    end
  end

  // One-clock bus pipeline with the overlay merged into rgb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out_hcount <= 11'd0;
      bus_out_hsync  <= 1'b0;
      bus_out_hblnk  <= 1'b0;
      bus_out_vcount <= 11'd0;
      bus_out_vsync  <= 1'b0;
      bus_out_vblnk  <= 1'b0;
      bus_out_rgb    <= 12'd0;
    end else begin
      bus_out_hcount <= bus_in_hcount;
      bus_out_hsync  <= bus_in_hsync;
      bus_out_hblnk  <= bus_in_hblnk;
      bus_out_vcount <= bus_in_vcount;
      bus_out_vsync  <= bus_in_vsync;
      bus_out_vblnk  <= bus_in_vblnk;
      bus_out_rgb    <= w_draw ? CURSOR_COLOR : bus_in_rgb;
    end
  end

  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign blink_on  = r_blink;
  assign frame_cnt = r_cnt;

endmodule
